// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: a registered state machine that steps each instruction
// through fetch, decode and execute states and drives the datapath strobes for every cycle.
module multicycle_control #(
   parameter int MEM_WAIT = 1,
   parameter int BR_EXT   = 1,
   parameter int STATE_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        instr,
   input  logic               mem_ready,
   output logic               RegDst,
   output logic               Jump,
   output logic               Branch,
   output logic               MemRead,
   output logic               MemtoReg,
   output logic               MemWrite,
   output logic               ALUSrc,
   output logic               RegWrite,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic [1:0]         ALUOp,
   output logic               illegal,
   output logic               done,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [STATE_W-1:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC_I, IWB, EXEC_R, RWB, BRANCH, JUMP
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  opcode;
   logic        mem_rdy;
   logic        unused_instr;

   logic        reg_dst_c, jump_c, branch_c, mem_read_c, memto_reg_c, mem_write_c;
   logic        alu_src_c, reg_write_c, ir_write_c, pc_write_c, illegal_c, done_c;
   logic [1:0]  alu_op_c;

   assign opcode       = instr[31:26];
   assign unused_instr = ^instr[25:0];
   assign mem_rdy      = (MEM_WAIT != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      reg_dst_c   = 1'b0;
      jump_c      = 1'b0;
      branch_c    = 1'b0;
      mem_read_c  = 1'b0;
      memto_reg_c = 1'b0;
      mem_write_c = 1'b0;
      alu_src_c   = 1'b0;
      reg_write_c = 1'b0;
      ir_write_c  = 1'b0;
      pc_write_c  = 1'b0;
      illegal_c   = 1'b0;
      done_c      = 1'b0;
      alu_op_c    = 2'b00;

      case (state_q)
         FETCH: begin
            mem_read_c = 1'b1;
            ir_write_c = mem_rdy;
            pc_write_c = mem_rdy;
            if (mem_rdy) state_d = DECODE;
         end
         DECODE: begin
            case (opcode)
               6'b100011, 6'b100000, 6'b100001,
               6'b101011, 6'b101000, 6'b101001: state_d = MEMADR;
               6'b001000, 6'b001100, 6'b001101, 6'b001010: state_d = EXEC_I;
               6'b000000: state_d = EXEC_R;
               6'b000100: state_d = BRANCH;
               6'b000101, 6'b000111: begin
                  if (BR_EXT != 0) begin
                     state_d = BRANCH;
                  end else begin
                     state_d   = FETCH;
                     illegal_c = 1'b1;
                  end
               end
               6'b000010: state_d = JUMP;
               default: begin
                  state_d   = FETCH;
                  illegal_c = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_c = 1'b1;
            // Loads are 100xxx and stores 101xxx, so opcode bit 3 separates them.
            state_d   = opcode[3] ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_read_c = 1'b1;
            alu_src_c  = 1'b1;
            if (mem_rdy) state_d = MEMWB;
         end
         MEMWB: begin
            memto_reg_c = 1'b1;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
            state_d     = FETCH;
         end
         MEMWR: begin
            mem_write_c = 1'b1;
            alu_src_c   = 1'b1;
            done_c      = mem_rdy;
            if (mem_rdy) state_d = FETCH;
         end
         EXEC_I: begin
            alu_src_c = 1'b1;
            alu_op_c  = (opcode == 6'b001000) ? 2'b00 : 2'b11;
            state_d   = IWB;
         end
         IWB: begin
            alu_src_c   = 1'b1;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
            alu_op_c    = (opcode == 6'b001000) ? 2'b00 : 2'b11;
            state_d     = FETCH;
         end
         EXEC_R: begin
            alu_op_c = 2'b10;
            state_d  = RWB;
         end
         RWB: begin
            reg_dst_c   = 1'b1;
            alu_op_c    = 2'b10;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            branch_c = 1'b1;
            alu_op_c = 2'b01;
            done_c   = 1'b1;
            state_d  = FETCH;
         end
         JUMP: begin
            jump_c  = 1'b1;
            done_c  = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Reset blanks every output combinationally, so nothing strobes while reset is held.
   always_comb begin
      {RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
       IRWrite, PCWrite, ALUOp, illegal, done} = '0;
      state = FETCH;
      if (!reset) begin
         {RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
          IRWrite, PCWrite, ALUOp, illegal, done} =
            {reg_dst_c, jump_c, branch_c, mem_read_c, memto_reg_c, mem_write_c, alu_src_c,
             reg_write_c, ir_write_c, pc_write_c, alu_op_c, illegal_c, done_c};
         state = state_q;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector table plus a random instruction stream for the multicycle control unit.
module tb_multicycle_control;

   localparam logic [13:0] RD = 14'h2000, JP = 14'h1000, BR = 14'h0800, MR = 14'h0400;
   localparam logic [13:0] M2R = 14'h0200, MW = 14'h0100, AS = 14'h0080, RW = 14'h0040;
   localparam logic [13:0] IR = 14'h0020, PC = 14'h0010, AO_SUB = 14'h0004, AO_R = 14'h0008;
   localparam logic [13:0] AO_I = 14'h000C, ILL = 14'h0002, DN = 14'h0001;

   localparam logic [31:0] LW = 32'h8C000000, SW = 32'hAC000000, ADDI = 32'h20000000;
   localparam logic [31:0] ORI = 32'h34000000, RTYPE = 32'h00000020, BEQ = 32'h10000000;
   localparam logic [31:0] BNE = 32'h14000000, BGTZ = 32'h1C000000, JMP = 32'h08000000;
   localparam logic [31:0] BAD = 32'hFC000000;

   typedef struct {
      string       name;
      bit          sel;
      logic        rst;
      logic [31:0] ins;
      logic        mr;
      logic [3:0]  expState;
      logic [13:0] expCtl;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_a = 1'b1, reset_b = 1'b1, mr_a = 1'b1, mr_b = 1'b1;
   logic [31:0] instr_a = '0, instr_b = '0;

   logic RegDst_a, Jump_a, Branch_a, MemRead_a, MemtoReg_a, MemWrite_a, ALUSrc_a;
   logic RegWrite_a, IRWrite_a, PCWrite_a, illegal_a, done_a;
   logic RegDst_b, Jump_b, Branch_b, MemRead_b, MemtoReg_b, MemWrite_b, ALUSrc_b;
   logic RegWrite_b, IRWrite_b, PCWrite_b, illegal_b, done_b;
   logic [1:0]  ALUOp_a, ALUOp_b;
   logic [3:0]  state_a, state_b;
   logic [13:0] ctl_a, ctl_b;

   assign ctl_a = {RegDst_a, Jump_a, Branch_a, MemRead_a, MemtoReg_a, MemWrite_a, ALUSrc_a,
                   RegWrite_a, IRWrite_a, PCWrite_a, ALUOp_a, illegal_a, done_a};
   assign ctl_b = {RegDst_b, Jump_b, Branch_b, MemRead_b, MemtoReg_b, MemWrite_b, ALUSrc_b,
                   RegWrite_b, IRWrite_b, PCWrite_b, ALUOp_b, illegal_b, done_b};

   multicycle_control #(.MEM_WAIT(1), .BR_EXT(1), .STATE_W(4)) dut_a (
      .clk(clk), .reset(reset_a), .instr(instr_a), .mem_ready(mr_a),
      .RegDst(RegDst_a), .Jump(Jump_a), .Branch(Branch_a), .MemRead(MemRead_a),
      .MemtoReg(MemtoReg_a), .MemWrite(MemWrite_a), .ALUSrc(ALUSrc_a),
      .RegWrite(RegWrite_a), .IRWrite(IRWrite_a), .PCWrite(PCWrite_a), .ALUOp(ALUOp_a),
      .illegal(illegal_a), .done(done_a), .state(state_a));

   multicycle_control #(.MEM_WAIT(0), .BR_EXT(0), .STATE_W(4)) dut_b (
      .clk(clk), .reset(reset_b), .instr(instr_b), .mem_ready(mr_b),
      .RegDst(RegDst_b), .Jump(Jump_b), .Branch(Branch_b), .MemRead(MemRead_b),
      .MemtoReg(MemtoReg_b), .MemWrite(MemWrite_b), .ALUSrc(ALUSrc_b),
      .RegWrite(RegWrite_b), .IRWrite(IRWrite_b), .PCWrite(PCWrite_b), .ALUOp(ALUOp_b),
      .illegal(illegal_b), .done(done_b), .state(state_b));

   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];

   task automatic addVec(input string n, input bit s, input logic r, input logic [31:0] i,
                         input logic m, input logic [3:0] st, input logic [13:0] c);
      vec_t v;
      v.name = n; v.sel = s; v.rst = r; v.ins = i; v.mr = m; v.expState = st; v.expCtl = c;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string n, input logic [17:0] got, input logic [17:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got state/ctl=%h expected=%h", n, got, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      if (v.sel == 1'b0) begin
         reset_a = v.rst; instr_a = v.ins; mr_a = v.mr; reset_b = 1'b1;
      end else begin
         reset_b = v.rst; instr_b = v.ins; mr_b = v.mr; reset_a = 1'b1;
      end
      #1;
      if (v.sel == 1'b0) checkOutput(v.name, {state_a, ctl_a}, {v.expState, v.expCtl});
      else               checkOutput(v.name, {state_b, ctl_b}, {v.expState, v.expCtl});
   endtask

   function automatic bit isLegal(input logic [5:0] op);
      case (op)
         6'b100011, 6'b100000, 6'b100001, 6'b101011, 6'b101000, 6'b101001,
         6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000000,
         6'b000100, 6'b000101, 6'b000111, 6'b000010: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   initial begin
      logic [5:0] legalOps [15];
      logic [5:0] op;
      int doneCount, legalCount, cyc;
      bit finished, sawIllegal;

      legalOps = '{6'h23, 6'h20, 6'h21, 6'h2B, 6'h28, 6'h29, 6'h08, 6'h0C, 6'h0D, 6'h0A,
                   6'h00, 6'h04, 6'h05, 6'h07, 6'h02};

      // Instance A: MEM_WAIT=1, BR_EXT=1
      addVec("rst0", 0, 1, LW, 1, 4'd0, 14'h0);
      addVec("rst1", 0, 1, LW, 1, 4'd0, 14'h0);
      addVec("lw_fetch", 0, 0, LW, 1, 4'd0, MR|IR|PC);
      addVec("lw_decode", 0, 0, LW, 1, 4'd1, 14'h0);
      addVec("lw_memadr", 0, 0, LW, 1, 4'd2, AS);
      addVec("lw_memrd", 0, 0, LW, 1, 4'd3, MR|AS);
      addVec("lw_memwb", 0, 0, LW, 1, 4'd4, M2R|RW|DN);
      addVec("sw_fetchwait", 0, 0, SW, 0, 4'd0, MR);
      addVec("sw_fetch", 0, 0, SW, 1, 4'd0, MR|IR|PC);
      addVec("sw_decode", 0, 0, SW, 1, 4'd1, 14'h0);
      addVec("sw_memadr", 0, 0, SW, 1, 4'd2, AS);
      addVec("sw_wait1", 0, 0, SW, 0, 4'd5, MW|AS);
      addVec("sw_wait2", 0, 0, SW, 0, 4'd5, MW|AS);
      addVec("sw_wait3", 0, 0, SW, 0, 4'd5, MW|AS);
      addVec("sw_last", 0, 0, SW, 1, 4'd5, MW|AS|DN);
      addVec("ori_fetch", 0, 0, ORI, 1, 4'd0, MR|IR|PC);
      addVec("ori_decode", 0, 0, ORI, 1, 4'd1, 14'h0);
      addVec("ori_exec", 0, 0, ORI, 1, 4'd6, AS|AO_I);
      addVec("ori_wb", 0, 0, ORI, 1, 4'd7, AS|RW|DN|AO_I);
      addVec("r_fetch", 0, 0, RTYPE, 1, 4'd0, MR|IR|PC);
      addVec("r_decode", 0, 0, RTYPE, 1, 4'd1, 14'h0);
      addVec("r_exec", 0, 0, RTYPE, 1, 4'd8, AO_R);
      addVec("r_wb", 0, 0, RTYPE, 1, 4'd9, RD|AO_R|RW|DN);
      addVec("beq_fetch", 0, 0, BEQ, 1, 4'd0, MR|IR|PC);
      addVec("beq_decode", 0, 0, BEQ, 1, 4'd1, 14'h0);
      addVec("beq_branch", 0, 0, BEQ, 1, 4'd10, BR|AO_SUB|DN);
      addVec("bne_fetch", 0, 0, BNE, 1, 4'd0, MR|IR|PC);
      addVec("bne_decode", 0, 0, BNE, 1, 4'd1, 14'h0);
      addVec("bne_branch", 0, 0, BNE, 1, 4'd10, BR|AO_SUB|DN);
      addVec("bgtz_fetch", 0, 0, BGTZ, 1, 4'd0, MR|IR|PC);
      addVec("bgtz_decode", 0, 0, BGTZ, 1, 4'd1, 14'h0);
      addVec("bgtz_branch", 0, 0, BGTZ, 1, 4'd10, BR|AO_SUB|DN);
      addVec("j_fetch", 0, 0, JMP, 1, 4'd0, MR|IR|PC);
      addVec("j_decode", 0, 0, JMP, 1, 4'd1, 14'h0);
      addVec("j_jump", 0, 0, JMP, 1, 4'd11, JP|DN);
      addVec("bad_fetch", 0, 0, BAD, 1, 4'd0, MR|IR|PC);
      addVec("bad_decode", 0, 0, BAD, 1, 4'd1, ILL);
      addVec("bad_refetch", 0, 0, BAD, 0, 4'd0, MR);
      addVec("lwr_fetch", 0, 0, LW, 1, 4'd0, MR|IR|PC);
      addVec("lwr_decode", 0, 0, LW, 1, 4'd1, 14'h0);
      addVec("lwr_memadr", 0, 0, LW, 1, 4'd2, AS);
      addVec("lwr_memrd_wait", 0, 0, LW, 0, 4'd3, MR|AS);
      addVec("lwr_reset", 0, 1, LW, 0, 4'd0, 14'h0);
      addVec("addi_fetch", 0, 0, ADDI, 1, 4'd0, MR|IR|PC);
      addVec("addi_decode", 0, 0, ADDI, 1, 4'd1, 14'h0);
      addVec("addi_exec", 0, 0, ADDI, 1, 4'd6, AS);
      addVec("addi_wb", 0, 0, ADDI, 1, 4'd7, AS|RW|DN);
      // Instance B: MEM_WAIT=0, BR_EXT=0
      addVec("b_rst", 1, 1, BNE, 0, 4'd0, 14'h0);
      addVec("b_bne_fetch", 1, 0, BNE, 0, 4'd0, MR|IR|PC);
      addVec("b_bne_decode", 1, 0, BNE, 0, 4'd1, ILL);
      addVec("b_lw_fetch", 1, 0, LW, 0, 4'd0, MR|IR|PC);
      addVec("b_lw_decode", 1, 0, LW, 0, 4'd1, 14'h0);
      addVec("b_lw_memadr", 1, 0, LW, 0, 4'd2, AS);
      addVec("b_lw_memrd", 1, 0, LW, 0, 4'd3, MR|AS);
      addVec("b_lw_memwb", 1, 0, LW, 0, 4'd4, M2R|RW|DN);
      addVec("b_sw_fetch", 1, 0, SW, 0, 4'd0, MR|IR|PC);
      addVec("b_sw_decode", 1, 0, SW, 0, 4'd1, 14'h0);
      addVec("b_sw_memadr", 1, 0, SW, 0, 4'd2, AS);
      addVec("b_sw_memwr", 1, 0, SW, 0, 4'd5, MW|AS|DN);
      addVec("b_bgtz_fetch", 1, 0, BGTZ, 0, 4'd0, MR|IR|PC);
      addVec("b_bgtz_decode", 1, 0, BGTZ, 0, 4'd1, ILL);
      addVec("b_after_ill", 1, 0, BGTZ, 0, 4'd0, MR|IR|PC);

      for (int k = 0; k < vecs.size(); k++) applyStimulus(vecs[k]);

      // Random instruction stream on instance A with random memory stalls.
      @(negedge clk);
      reset_a = 1'b1; reset_b = 1'b1; instr_a = '0;
      @(posedge clk); #1;
      doneCount = 0;
      legalCount = 0;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 2) != 0) op = legalOps[$urandom_range(0, 14)];
         else                           op = 6'($urandom_range(0, 63));
         instr_a = {op, 26'($urandom)};
         if (isLegal(op)) legalCount++;
         finished = 1'b0;
         sawIllegal = 1'b0;
         cyc = 0;
         while (!finished && cyc < 100) begin
            @(negedge clk);
            reset_a = 1'b0;
            mr_a = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if ($countones({RegWrite_a, MemWrite_a, Branch_a, Jump_a}) > 1) begin
               failures++;
               $display("[TB] FAIL strobe_exclusive: got %b expected at most one set",
                        {RegWrite_a, MemWrite_a, Branch_a, Jump_a});
            end
            if (done_a) begin doneCount++; finished = 1'b1; end
            if (illegal_a) begin sawIllegal = 1'b1; finished = 1'b1; end
            cyc++;
         end
         checks++;
         if (!finished) begin
            failures++;
            $display("[TB] FAIL rand_timeout: instr %h never finished", instr_a);
         end else if (sawIllegal == isLegal(op)) begin
            failures++;
            $display("[TB] FAIL rand_illegal: op %b got illegal=%0b expected %0b",
                     op, sawIllegal, !isLegal(op));
         end
         @(posedge clk); #1;
      end
      checkOutput("rand_done_count", 18'(doneCount), 18'(legalCount));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
